counter_updown: RTL and testbench

Parametrised synchronous up/down counter: the successor to the 8-bit load/increment counter. It adds:
- a down direction;
- a programmable modulus;
- wrap or saturate overflow modes;
- registered carry/borrow pulses;
- terminal-count flags.

It serves as the general-purpose event/address counter for datapath and control units; `q` feeds downstream registers and comparators directly.

---
 rtl/counter_pkg.sv | 16 +
 rtl/counter_step.sv | 59 +++++
 rtl/counter_updown.sv | 75 +++++++
 tb/tb_counter_updown.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and helpers for the counter family.
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    // Highest legal count value: MODULUS-1, or all-ones when MODULUS is 0.
    function automatic int unsigned cnt_top(input int unsigned width, input int unsigned modulus);
        longint unsigned full;
        full = (64'd1 << width) - 64'd1;
        return (modulus == 0) ? 32'(full) : (modulus - 32'd1);
    endfunction

endpackage

// File: rtl/counter_step.sv
// Combinational next-count and event-flag logic for counter_updown.
module counter_step
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MODULUS = 0,
    parameter cnt_mode_e   MODE    = CNT_WRAP
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic             ld_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] q_next_o,
    output logic             carry_next_o,
    output logic             borrow_next_o,
    output logic             ld_err_next_o
);

    localparam logic [WIDTH:0]   TOP_W = (WIDTH+1)'(cnt_top(WIDTH, MODULUS));
    localparam logic [WIDTH-1:0] TOP_Q = WIDTH'(TOP_W);

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] data_ext;

    assign q_ext    = {1'b0, q_i};
    assign data_ext = {1'b0, data_in_i};

    // Load beats counting; the limit compare is against TOP, never rollover.
    always_comb begin
        q_next_o      = q_i;
        carry_next_o  = 1'b0;
        borrow_next_o = 1'b0;
        ld_err_next_o = 1'b0;
        if (ld_i) begin
            if (data_ext > TOP_W) begin
                q_next_o      = TOP_Q;
                ld_err_next_o = 1'b1;
            end else begin
                q_next_o = data_in_i;
            end
        end else if (inc_i && !dec_i) begin
            if (q_ext >= TOP_W) begin
                carry_next_o = 1'b1;
                q_next_o     = (MODE == CNT_WRAP) ? '0 : TOP_Q;
            end else begin
                q_next_o = WIDTH'(q_ext + (WIDTH+1)'(1));
            end
        end else if (dec_i && !inc_i) begin
            if (q_ext == '0) begin
                borrow_next_o = 1'b1;
                q_next_o      = (MODE == CNT_WRAP) ? TOP_Q : '0;
            end else begin
                q_next_o = WIDTH'(q_ext - (WIDTH+1)'(1));
            end
        end
    end

endmodule

// File: rtl/counter_updown.sv
// Parametrised up/down counter with modulus, wrap/saturate, event pulses and terminal flags.
module counter_updown
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MODULUS = 0,
    parameter cnt_mode_e   MODE    = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ld,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] q,
    output logic             carry,
    output logic             borrow,
    output logic             tc_max,
    output logic             tc_zero,
    output logic             ld_err
);

    localparam logic [WIDTH-1:0] TOP_Q = WIDTH'(cnt_top(WIDTH, MODULUS));

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("counter_updown: WIDTH must be 2..32");
    end
    if (!(MODULUS == 0 || (MODULUS >= 2 && 64'(MODULUS) <= (64'd1 << WIDTH)))) begin : g_bad_modulus
        $error("counter_updown: MODULUS must be 0 or 2..2^WIDTH");
    end

    logic [WIDTH-1:0] q_q, q_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             ld_err_q, ld_err_d;

    counter_step #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS),
        .MODE    (MODE)
    ) u_step (
        .q_i           (q_q),
        .data_in_i     (data_in),
        .ld_i          (ld),
        .inc_i         (inc),
        .dec_i         (dec),
        .q_next_o      (q_d),
        .carry_next_o  (carry_d),
        .borrow_next_o (borrow_d),
        .ld_err_next_o (ld_err_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q      <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            ld_err_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            ld_err_q <= ld_err_d;
        end
    end

    assign q       = q_q;
    assign carry   = carry_q;
    assign borrow  = borrow_q;
    assign ld_err  = ld_err_q;
    // Terminal flags decode the registered count directly.
    assign tc_max  = (q_q == TOP_Q);
    assign tc_zero = (q_q == '0);

endmodule

// File: tb/tb_counter_updown.sv
// Scoreboard bench: three counter configurations driven in lockstep against an arithmetic model.
module tb_counter_updown;
    import counter_pkg::*;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] q;
        logic         carry;
        logic         borrow;
        logic         ld_err;
        logic         tc_max;
        logic         tc_zero;
    } exp_t;

    typedef struct packed {
        exp_t d2;
        exp_t d1;
        exp_t d0;
    } exp3_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         ld = 1'b0;
    logic         inc = 1'b0;
    logic         dec = 1'b0;

    logic [W-1:0] q_w      [3];
    logic         carry_w  [3];
    logic         borrow_w [3];
    logic         tcmax_w  [3];
    logic         tczero_w [3];
    logic         lderr_w  [3];

    int n_cmp = 0;
    int n_bad = 0;

    exp3_t sb[$];

    // Reference state: full-range wrap, mod-10 wrap, mod-10 saturate.
    int mq  [3] = '{0, 0, 0};
    int top [3] = '{255, 9, 9};
    int sat [3] = '{0, 0, 1};

    always #5 clk = ~clk;

    counter_updown #(.WIDTH(W), .MODULUS(0), .MODE(CNT_WRAP)) dut0 (
        .clk(clk), .rst(rst), .data_in(data_in), .ld(ld), .inc(inc), .dec(dec),
        .q(q_w[0]), .carry(carry_w[0]), .borrow(borrow_w[0]),
        .tc_max(tcmax_w[0]), .tc_zero(tczero_w[0]), .ld_err(lderr_w[0]));

    counter_updown #(.WIDTH(W), .MODULUS(10), .MODE(CNT_WRAP)) dut1 (
        .clk(clk), .rst(rst), .data_in(data_in), .ld(ld), .inc(inc), .dec(dec),
        .q(q_w[1]), .carry(carry_w[1]), .borrow(borrow_w[1]),
        .tc_max(tcmax_w[1]), .tc_zero(tczero_w[1]), .ld_err(lderr_w[1]));

    counter_updown #(.WIDTH(W), .MODULUS(10), .MODE(CNT_SAT)) dut2 (
        .clk(clk), .rst(rst), .data_in(data_in), .ld(ld), .inc(inc), .dec(dec),
        .q(q_w[2]), .carry(carry_w[2]), .borrow(borrow_w[2]),
        .tc_max(tcmax_w[2]), .tc_zero(tczero_w[2]), .ld_err(lderr_w[2]));

    function automatic exp_t model_step(input int i, input logic r, input logic l,
                                        input logic up, input logic dn, input int d);
        exp_t e;
        int   t;
        t = top[i];
        e = '0;
        if (r) begin
            mq[i] = 0;
        end else if (l) begin
            if (d > t) begin
                mq[i] = t;
                e.ld_err = 1'b1;
            end else begin
                mq[i] = d;
            end
        end else if (up && !dn) begin
            e.carry = (mq[i] == t);
            mq[i] = (sat[i] != 0) ? ((mq[i] + 1 > t) ? t : mq[i] + 1) : (mq[i] + 1) % (t + 1);
        end else if (dn && !up) begin
            e.borrow = (mq[i] == 0);
            mq[i] = (sat[i] != 0) ? ((mq[i] == 0) ? 0 : mq[i] - 1) : (mq[i] + t) % (t + 1);
        end
        e.q       = W'(mq[i]);
        e.tc_max  = (mq[i] == t);
        e.tc_zero = (mq[i] == 0);
        return e;
    endfunction

    task automatic step(input logic r, input logic l, input logic up, input logic dn, input int d);
        exp3_t x;
        @(negedge clk);
        rst = r; ld = l; inc = up; dec = dn; data_in = W'(d);
        x.d0 = model_step(0, r, l, up, dn, d);
        x.d1 = model_step(1, r, l, up, dn, d);
        x.d2 = model_step(2, r, l, up, dn, d);
        sb.push_back(x);
    endtask

    function automatic void check(input int i, input exp_t e);
        exp_t g;
        g = {q_w[i], carry_w[i], borrow_w[i], lderr_w[i], tcmax_w[i], tczero_w[i]};
        n_cmp++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL dut%0d @%0t: got q=%0d c=%b b=%b lderr=%b tmax=%b tzero=%b, want q=%0d c=%b b=%b lderr=%b tmax=%b tzero=%b",
                     i, $time, g.q, g.carry, g.borrow, g.ld_err, g.tc_max, g.tc_zero,
                     e.q, e.carry, e.borrow, e.ld_err, e.tc_max, e.tc_zero);
        end
    endfunction

    // Monitor: outputs are valid every cycle, so pop one entry per edge once stimulus began.
    initial begin
        exp3_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check(0, x.d0);
                check(1, x.d1);
                check(2, x.d2);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        // Reset, then a full 256-step walk with wrap back to 0.
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 256; k++) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        // Modulus-10 count through TOP, then underflow from zero.
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        // Saturation at TOP and at zero.
        step(0, 1, 0, 0, 9);
        for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        // Out-of-range load, then load beating a same-cycle increment.
        step(0, 1, 0, 0, 200);
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 5);
        step(0, 1, 0, 1, 255);
        // inc and dec together hold.
        step(0, 1, 0, 0, 4);
        for (int k = 0; k < 5; k++) step(0, 0, 1, 1, 0);
        // Reset wins over a concurrent load.
        step(0, 1, 0, 0, 7);
        step(1, 1, 0, 0, 3);
        step(0, 0, 0, 0, 0);
        // Random traffic.
        for (int k = 0; k < 2000; k++) begin
            r = int'($urandom_range(0, 99));
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 (r < 80) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 255)));
        end
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
